// File: rtl/span_margin_seq_if.sv
// span_margin_seq_if: Avalon-MM style register bus between a host and span_margin_seq.
//   chipselect/write/read/offset/writeData : host -> slave access strobes, word offset and write data
//   readData                               : slave -> host registered read data
//   irq                                    : slave -> host level interrupt
interface span_margin_seq_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
);
    logic              chipselect;
    logic              write;
    logic              read;
    logic [ADDR_W-1:0] offset;
    logic [DATA_W-1:0] writeData;
    logic [DATA_W-1:0] readData;
    logic              irq;

    modport master (
        output chipselect, write, read, offset, writeData,
        input  readData, irq
    );

    modport slave (
        input  chipselect, write, read, offset, writeData,
        output readData, irq
    );
endinterface

// File: rtl/span_margin_seq.sv
// span_margin_seq: SPAN initial-margin front end, a register slave that sequences scan, spread
// and cross-commodity engines and forms a saturating margin sum.
//   clk, reset                   : clock, synchronous active-high reset
//   bus (slave)                  : register access, registered readData, level irq
//   psr, positions, maturities   : configuration presented to the engines
//   *_start / *_done / *_res     : per-engine one-cycle start pulse, completion strobe and result
module span_margin_seq #(
    parameter int DATA_W   = 16,
    parameter int N_MONTHS = 8,
    parameter int ADDR_W   = 6,
    parameter int TIMEOUT  = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    span_margin_seq_if.slave           bus,
    output logic [DATA_W-1:0]          psr,
    output logic [N_MONTHS*DATA_W-1:0] positions,
    output logic [N_MONTHS*8-1:0]      maturities,
    output logic                       scan_start,
    output logic                       spread_start,
    output logic                       cross_start,
    input  logic                       scan_done,
    input  logic                       spread_done,
    input  logic                       cross_done,
    input  logic [DATA_W-1:0]          scan_res,
    input  logic [DATA_W-1:0]          spread_res,
    input  logic [DATA_W-1:0]          cross_res
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SCAN   = 3'd1;
    localparam logic [2:0] SPREAD = 3'd2;
    localparam logic [2:0] CROSS  = 3'd3;
    localparam logic [2:0] SUM    = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;
    localparam logic [2:0] ERR    = 3'd6;
    localparam int CW = $clog2(TIMEOUT + 1);
    // one extra offset bit so the end of the maturity window never wraps to zero
    localparam int AW = ADDR_W + 1;

    logic [2:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] psr_q, margin_q, scan_q, spread_q, cross_q;
    logic [DATA_W-1:0] pos_q [N_MONTHS];
    logic [7:0]        mat_q [N_MONTHS];
    logic              irq_en_q, done_q, ovf_q, to_q, wr_err_q;
    logic              scan_start_q, spread_start_q, cross_start_q;
    logic [AW-1:0]     off;
    logic              wr_en, rd_en, busy, waiting, tmo, ctrl_wr, start_wr, cfg_wr, clr, sat;
    logic [DATA_W+1:0] sum;

    assign off      = {1'b0, bus.offset};
    assign wr_en    = bus.chipselect & bus.write;
    // a read paired with a write is treated as a pure write
    assign rd_en    = bus.chipselect & bus.read & ~bus.write;
    assign busy     = state_q inside {SCAN, SPREAD, CROSS, SUM};
    assign waiting  = state_q inside {SCAN, SPREAD, CROSS};
    assign tmo      = waiting & (cnt_q == CW'(TIMEOUT - 1));
    assign ctrl_wr  = wr_en & (off == AW'(0));
    assign start_wr = ctrl_wr & bus.writeData[0] & (state_q == IDLE);
    assign cfg_wr   = wr_en & ((off == AW'(2)) | ((off >= AW'(8)) & (off < AW'(8 + 2*N_MONTHS))));
    assign clr      = (rd_en & (off == AW'(1))) | (ctrl_wr & bus.writeData[2]) | start_wr;
    assign sum      = {2'b00, scan_q} + {2'b00, spread_q} + {2'b00, cross_q};
    assign sat      = |sum[DATA_W +: 2];

    // an engine done wins over a timeout landing on the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start_wr ? SCAN : IDLE;
            SCAN:    state_d = scan_done ? SPREAD : tmo ? ERR : SCAN;
            SPREAD:  state_d = spread_done ? CROSS : tmo ? ERR : SPREAD;
            CROSS:   state_d = cross_done ? SUM : tmo ? ERR : CROSS;
            SUM:     state_d = DONE;
            default: state_d = IDLE;
        endcase
        cnt_d = (waiting && state_d == state_q) ? cnt_q + 1'b1 : '0;
    end

    always_comb begin
        rd_d = '0;
        case (off)
            AW'(0):  rd_d = DATA_W'(irq_en_q);
            AW'(1):  rd_d = DATA_W'({wr_err_q, to_q, ovf_q, done_q, busy});
            AW'(2):  rd_d = psr_q;
            AW'(3):  rd_d = margin_q;
            AW'(4):  rd_d = scan_q;
            AW'(5):  rd_d = spread_q;
            AW'(6):  rd_d = cross_q;
            default: rd_d = '0;
        endcase
        for (int k = 0; k < N_MONTHS; k++) begin
            if (off == AW'(8 + k)) rd_d = pos_q[k];
            if (off == AW'(8 + N_MONTHS + k)) rd_d = DATA_W'(mat_q[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            rd_q           <= '0;
            psr_q          <= '0;
            margin_q       <= '0;
            scan_q         <= '0;
            spread_q       <= '0;
            cross_q        <= '0;
            irq_en_q       <= 1'b0;
            done_q         <= 1'b0;
            ovf_q          <= 1'b0;
            to_q           <= 1'b0;
            wr_err_q       <= 1'b0;
            scan_start_q   <= 1'b0;
            spread_start_q <= 1'b0;
            cross_start_q  <= 1'b0;
            for (int k = 0; k < N_MONTHS; k++) begin
                pos_q[k] <= '0;
                mat_q[k] <= '0;
            end
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            scan_start_q   <= start_wr;
            spread_start_q <= (state_q == SCAN) && (state_d == SPREAD);
            cross_start_q  <= (state_q == SPREAD) && (state_d == CROSS);
            if (state_q == SCAN && scan_done) scan_q <= scan_res;
            if (state_q == SPREAD && spread_done) spread_q <= spread_res;
            if (state_q == CROSS && cross_done) cross_q <= cross_res;
            if (state_q == SUM) margin_q <= sat ? '1 : sum[DATA_W-1:0];
            if (ctrl_wr) irq_en_q <= bus.writeData[1];
            if (cfg_wr && !busy && off == AW'(2)) psr_q <= bus.writeData;
            for (int k = 0; k < N_MONTHS; k++) begin
                if (cfg_wr && !busy && off == AW'(8 + k)) pos_q[k] <= bus.writeData;
                if (cfg_wr && !busy && off == AW'(8 + N_MONTHS + k)) mat_q[k] <= bus.writeData[7:0];
            end
            // sticky flags: a new event on the clearing cycle still sets the flag
            done_q   <= (state_q == SUM) | (state_d == ERR) | (done_q & ~clr);
            ovf_q    <= ((state_q == SUM) & sat) | (ovf_q & ~clr);
            to_q     <= (state_d == ERR) | (to_q & ~clr);
            wr_err_q <= (cfg_wr & busy) | (wr_err_q & ~clr);
            if (rd_en) rd_q <= rd_d;
        end
    end

    for (genvar i = 0; i < N_MONTHS; i++) begin : g_flat
        assign positions[i*DATA_W +: DATA_W] = pos_q[i];
        assign maturities[i*8 +: 8]          = mat_q[i];
    end

    assign psr          = psr_q;
    assign scan_start   = scan_start_q;
    assign spread_start = spread_start_q;
    assign cross_start  = cross_start_q;
    assign bus.readData = rd_q;
    assign bus.irq      = irq_en_q & done_q;
endmodule

// File: tb/tb_span_margin_seq.sv
// tb_span_margin_seq: directed scoreboard bench for span_margin_seq with behavioural engines.
module tb_span_margin_seq;
    localparam int DW = 16;
    localparam int NM = 8;
    localparam int AW = 6;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    span_margin_seq_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    logic [DW-1:0]    psr;
    logic [NM*DW-1:0] positions;
    logic [NM*8-1:0]  maturities;
    logic             scan_start, spread_start, cross_start;
    logic             scan_done = 1'b0, spread_done = 1'b0, cross_done = 1'b0;
    logic [DW-1:0]    scan_res = '0, spread_res = '0, cross_res = '0;

    span_margin_seq #(.DATA_W(DW), .N_MONTHS(NM), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .psr(psr), .positions(positions), .maturities(maturities),
        .scan_start(scan_start), .spread_start(spread_start), .cross_start(cross_start),
        .scan_done(scan_done), .spread_done(spread_done), .cross_done(cross_done),
        .scan_res(scan_res), .spread_res(spread_res), .cross_res(cross_res)
    );

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] exp_q [$];
    string name_q [$];
    logic [DW-1:0] exp_v;
    string exp_n;
    logic rv = 1'b0;
    int n_scan = 0, n_spread = 0, n_cross = 0;
    logic [DW-1:0] r_scan = 16'd40, r_spread = 16'd25, r_cross = 16'd10;
    logic en_spread = 1'b1;
    int d_cross = 3;

    // a read accepted at this edge shows up on readData until the next edge
    always @(posedge clk) rv <= bus.chipselect & bus.read & ~bus.write;

    always @(negedge clk) begin
        if (scan_start) n_scan++;
        if (spread_start) n_spread++;
        if (cross_start) n_cross++;
        if (rv) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_read got=%h", bus.readData);
            end else begin
                exp_v = exp_q.pop_front();
                exp_n = name_q.pop_front();
                if (bus.readData !== exp_v) begin
                    failures++;
                    $display("FAIL %s got=%h exp=%h", exp_n, bus.readData, exp_v);
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (scan_start) begin
            repeat (3) @(posedge clk);
            #1 scan_done = 1'b1; scan_res = r_scan;
            @(posedge clk);
            #1 scan_done = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (spread_start && en_spread) begin
            repeat (3) @(posedge clk);
            #1 spread_done = 1'b1; spread_res = r_spread;
            @(posedge clk);
            #1 spread_done = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (cross_start) begin
            repeat (d_cross) @(posedge clk);
            #1 cross_done = 1'b1; cross_res = r_cross;
            @(posedge clk);
            #1 cross_done = 1'b0;
        end
    end

    task automatic chk(input string n, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.read = 1'b0; bus.offset = a; bus.writeData = d;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.write = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
        bus.chipselect = 1'b1; bus.write = 1'b0; bus.read = 1'b1; bus.offset = a;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.read = 1'b0;
    endtask

    task automatic rw(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.read = 1'b1; bus.offset = a; bus.writeData = d;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_irq(input string n);
        int k = 0;
        while (!bus.irq && k < 200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!bus.irq) begin
            failures++;
            $display("FAIL %s irq_wait got=0 exp=1", n);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int k;
        int cnt;
        bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
        bus.offset = '0; bus.writeData = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_irq", 128'(bus.irq), 0);
        chk("rst_psr", 128'(psr), 0);
        chk("rst_positions", 128'(positions), 0);
        chk("rst_maturities", 128'(maturities), 0);
        chk("rst_readdata", 128'(bus.readData), 0);
        chk("rst_starts", 128'({scan_start, spread_start, cross_start}), 0);
        rd(AW'(1), 16'h0000, "rst_status");
        rd(AW'(3), 16'h0000, "rst_margin");

        wr(AW'(2), 16'd100);
        for (int i = 0; i < NM; i++) wr(AW'(8 + i), DW'(i + 1));
        rd(AW'(2), 16'd100, "psr_rb");
        rd(AW'(11), 16'd4, "pos3_rb");
        chk("psr_out", 128'(psr), 100);
        chk("pos3_out", 128'(positions[3*DW +: DW]), 4);
        n_scan = 0; n_spread = 0; n_cross = 0;
        wr(AW'(0), 16'h0001);
        idle(40);
        chk("start_pulses", 128'({n_scan, n_spread, n_cross}), {32'd1, 32'd1, 32'd1});
        chk("irq_masked", 128'(bus.irq), 0);
        wr(AW'(0), 16'h0002);
        chk("irq_enabled", 128'(bus.irq), 1);
        rd(AW'(1), 16'h0002, "status_done");
        rd(AW'(3), 16'd75, "margin");
        rd(AW'(4), 16'd40, "scan_res");
        rd(AW'(5), 16'd25, "spread_res");
        rd(AW'(6), 16'd10, "cross_res");
        rd(AW'(0), 16'h0001, "ctrl_rb");
        chk("irq_after_status_read", 128'(bus.irq), 0);

        r_scan = 16'hFFF0; r_spread = 16'h0020; r_cross = 16'h0000;
        wr(AW'(0), 16'h0003);
        wait_irq("ovf_run");
        rd(AW'(1), 16'h0006, "status_ovf");
        rd(AW'(3), 16'hFFFF, "margin_sat");
        rd(AW'(1), 16'h0000, "status_cleared");

        r_scan = 16'd40; r_spread = 16'd25; r_cross = 16'd10;
        wr(AW'(0), 16'h0003);
        wr(AW'(11), 16'd7);
        wait_irq("wrerr_run");
        rd(AW'(11), 16'd4, "pos3_kept");
        rd(AW'(1), 16'h0012, "status_wrerr");
        rd(AW'(3), 16'd75, "margin_wrerr");

        en_spread = 1'b0;
        n_cross = 0;
        wr(AW'(0), 16'h0003);
        k = 0;
        @(negedge clk);
        while (!spread_start && k < 50) begin
            @(negedge clk);
            k++;
        end
        cnt = 0;
        while (!bus.irq && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("timeout_cycles", 128'(cnt), 16);
        @(posedge clk); #1;
        rd(AW'(1), 16'h000A, "status_timeout");
        rd(AW'(3), 16'd75, "margin_kept");
        chk("no_cross_start", 128'(n_cross), 0);
        en_spread = 1'b1;

        d_cross = 10;
        wr(AW'(0), 16'h0003);
        k = 0;
        @(negedge clk);
        while (!cross_start && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("cross_reached", 128'(cross_start), 1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("rrst_irq", 128'(bus.irq), 0);
        chk("rrst_psr", 128'(psr), 0);
        chk("rrst_positions", 128'(positions), 0);
        chk("rrst_readdata", 128'(bus.readData), 0);
        chk("rrst_starts", 128'({scan_start, spread_start, cross_start}), 0);
        idle(20);
        rd(AW'(1), 16'h0000, "status_after_rst");
        rd(AW'(6), 16'h0000, "cross_res_after_rst");
        d_cross = 3;
        wr(AW'(0), 16'h0003);
        wait_irq("clean_run");
        rd(AW'(3), 16'd75, "margin_clean");
        wr(AW'(0), 16'h0006);
        chk("irq_clear_status", 128'(bus.irq), 0);
        rd(AW'(1), 16'h0000, "status_clr");

        wr(AW'(8 + NM + 2), 16'h01A5);
        rd(AW'(8 + NM + 2), 16'h00A5, "mat2_rb");
        chk("mat2_out", 128'(maturities[2*8 +: 8]), 8'hA5);
        rw(AW'(2), 16'h0055);
        chk("rw_hold", 128'(bus.readData), 16'h00A5);
        rd(AW'(2), 16'h0055, "rw_write");
        rd(AW'(7), 16'h0000, "reserved");
        wr(AW'(40), 16'h1234);
        rd(AW'(40), 16'h0000, "unmapped");

        idle(2);
        chk("scoreboard_empty", 128'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/span_margin_seq.md
Name: span_margin_seq

Overview:
- Parametrised successor of the team's SPAN initial-margin front end: Avalon-MM-style register slave plus a sequencing FSM.
- Holds per-month position and maturity tables for N_MONTHS contract months.
- Runs three external calculation engines (scan risk, intermonth spread, cross-commodity) in order over start/done handshakes, then forms a saturating margin sum.
- Adds a status register, a per-engine timeout, a write-while-busy error flag and an interrupt.

Parameters:
- DATA_W, 16, register/result width.
- N_MONTHS, 8, contract months (positions and maturities); 1..16.
- ADDR_W, 6, offset width; 8+2*N_MONTHS <= 2^ADDR_W.
- TIMEOUT, 1024, max cycles waiting for any engine done; >= 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- chipselect  in  1  slave select.
- write  in  1  write strobe.
- read  in  1  read strobe.
- offset  in  ADDR_W  word offset.
- writeData  in  DATA_W  write data.
- readData  out  DATA_W  read data, registered.
- irq  out  1  level interrupt.
- psr  out  DATA_W  price scan range to engines.
- positions  out  N_MONTHS*DATA_W  flattened positions; month i at [i*DATA_W +: DATA_W].
- maturities  out  N_MONTHS*8  flattened maturities.
- scan_start / spread_start / cross_start  out  1 each  one-cycle start pulses.
- scan_done / spread_done / cross_done  in  1 each  engine completion, sampled in the matching wait state only.
- scan_res / spread_res / cross_res  in  DATA_W each  engine result, valid with its done.

Behaviour:
- Reset value of all outputs and registers is 0; FSM goes to IDLE. Reset mid-operation aborts the run with no irq, and later engine done pulses are ignored.
- Register map:
  - 0 CTRL: W bit0 start (self-clearing), bit1 irq_en, bit2 clear_status (self-clearing); R returns {irq_en}.
  - 1 STATUS (R): bit0 busy, bit1 done, bit2 overflow, bit3 timeout, bit4 wr_err.
  - 2 PSR (R/W).
  - 3 MARGIN (R).
  - 4/5/6 SCAN_RES/SPREAD_RES/CROSS_RES (R).
  - 7 reserved, reads 0.
  - 8..8+N_MONTHS-1 positions (R/W).
  - 8+N_MONTHS..8+2*N_MONTHS-1 maturities (R/W, writeData[7:0], read zero-extended).
  - Unmapped offsets: writes ignored, reads return 0.
- Reads: chipselect&read in cycle T gives readData at T+1. readData holds its value otherwise.
- Simultaneous read and write: the write takes effect and readData is unchanged.
- FSM states: IDLE, SCAN, SPREAD, CROSS, SUM, DONE, ERR.
  - IDLE: CTRL.start write moves to SCAN and asserts scan_start for the first cycle.
  - SCAN: on scan_done, latch scan_res, go to SPREAD and pulse spread_start. SPREAD and CROSS follow the same pattern.
  - CROSS: on cross_done go to SUM.
  - SUM (1 cycle): MARGIN = scan+spread+cross in DATA_W+2 bits. If the sum exceeds 2^DATA_W-1, MARGIN saturates to all-ones and overflow is set. Then go to DONE.
  - DONE/ERR: go to IDLE on the next cycle after setting done (or timeout), clearing busy.
- Busy is high from the cycle after start through SUM. Start while busy is ignored.
- Any config write (PSR/positions/maturities) while busy is dropped and sets wr_err.
- Timeout: a per-state cycle counter resets on every state entry. When it reaches TIMEOUT with no done, go to ERR: timeout=1, done=1, MARGIN left unchanged.
- Done arriving on the same cycle as the counter reaching TIMEOUT counts as done; it takes priority.
- irq = irq_en & done. A STATUS read or clear_status clears done, overflow, timeout and wr_err on the following cycle. A new start also clears them.
- A done input outside its wait state is ignored.

Test Plan:
- Write PSR=100, positions 1..8, start. Engines answer done after 3 cycles with 40/25/10 -> MARGIN=75; STATUS=0x02; each start is a single-cycle pulse; irq=1 only if irq_en.
- Results 0xFFF0/0x0020/0 -> MARGIN=0xFFFF, overflow=1.
- TIMEOUT=16, spread_done never asserted -> ERR after 16 cycles in SPREAD; STATUS=0x0A; cross_start never pulses.
- Write position[3]=7 while busy -> read back returns the old value; wr_err=1; the run completes normally.
- Reset asserted in CROSS -> all outputs 0 next cycle; a late cross_done is ignored; a new start runs cleanly.
- Read offset 8+N_MONTHS+2 after writing 0x1A5 -> returns 0x00A5 one cycle after read; offset 7 reads 0.
